// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - FIFO drain-side UART-style serial transmitter
//
// Pulls WIDTH-bit words from a synchronous FIFO read port and sends each one
// as a serial frame: start bit (0), data bits LSB first, optional even parity
// bit, stop bit (1). The line idles high.
//
// Optional feature macro: FIFO_UART_TX_PARITY_EN
//   defined   -> a PARITY bit (XOR of the word) is sent between DATA and STOP
//   undefined -> no parity logic; DATA is followed directly by STOP
//
// Parameters:
//   WIDTH        data word width, equal to the FIFO width
//   CLKS_PER_BIT clk cycles per serial bit (>= 1)
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   en          allows new frames to start; looked at only when deciding to fetch
//   fifo_empty  FIFO empty flag
//   fifo_data   FIFO data_out, valid the cycle after the FIFO samples re=1
//   fifo_re     FIFO read enable, registered one-cycle pulse per word
//   tx          serial output, idle high
//   busy        high from the fetch decision through the end of the stop bit
//   word_done   one-cycle pulse on the last cycle of each stop bit

module fifo_uart_tx #(
    parameter int WIDTH        = 16,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             fifo_re,
    output logic             tx,
    output logic             busy,
    output logic             word_done
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT) + 1;
    localparam int BIT_W  = $clog2(WIDTH) + 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        LATCH,
        START,
        DATA,
`ifdef FIFO_UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [BAUD_W-1:0]  baud;
    logic [BAUD_W-1:0]  baud_next;
    logic [BIT_W-1:0]   bit_cnt;
    logic [BIT_W-1:0]   bit_cnt_next;
    logic [WIDTH-1:0]   shreg;
    logic [WIDTH-1:0]   shreg_next;
    logic               baud_end;
    logic               fetch;

`ifdef FIFO_UART_TX_PARITY_EN
    logic               parity_q;
`endif

    assign baud_end = (baud == BAUD_LAST);

    // A new word is fetched only if the consumer is enabled and the FIFO
    // has something in it, so an empty FIFO is never read.
    assign fetch = en && !fifo_empty;

    // ------------------------------------------------------------------
    // State register and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            baud    <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            fifo_re <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_next;
            baud    <= baud_next;
            bit_cnt <= bit_cnt_next;
            shreg   <= shreg_next;
            // Registered versions of "the next state is REQ / not IDLE" so
            // both flags change on the same edge as the state transition.
            fifo_re <= (state_next == REQ);
            busy    <= (state_next != IDLE);
        end
    end

`ifdef FIFO_UART_TX_PARITY_EN
    // Parity is taken from the FIFO word as it is latched, so it does not
    // depend on the shift register that is consumed during DATA.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parity_q <= 1'b0;
        end else if (state == LATCH) begin
            parity_q <= ^fifo_data;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next   = state;
        baud_next    = baud;
        bit_cnt_next = bit_cnt;
        shreg_next   = shreg;

        case (state)
            IDLE: begin
                if (fetch) begin
                    state_next = REQ;
                end
            end

            REQ: begin
                // The FIFO samples re at the closing edge of this cycle.
                state_next = LATCH;
            end

            LATCH: begin
                shreg_next   = fifo_data;
                baud_next    = '0;
                bit_cnt_next = '0;
                state_next   = START;
            end

            START: begin
                if (baud_end) begin
                    baud_next  = '0;
                    state_next = DATA;
                end else begin
                    baud_next = baud + 1'b1;
                end
            end

            DATA: begin
                if (baud_end) begin
                    baud_next    = '0;
                    shreg_next   = shreg >> 1;
                    bit_cnt_next = bit_cnt + 1'b1;
                    if (bit_cnt == BIT_LAST) begin
`ifdef FIFO_UART_TX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end else begin
                    baud_next = baud + 1'b1;
                end
            end

`ifdef FIFO_UART_TX_PARITY_EN
            PARITY: begin
                if (baud_end) begin
                    baud_next  = '0;
                    state_next = STOP;
                end else begin
                    baud_next = baud + 1'b1;
                end
            end
`endif

            STOP: begin
                if (baud_end) begin
                    baud_next = '0;
                    // Chaining straight into REQ keeps busy high and gives
                    // the minimum two-cycle gap between frames.
                    state_next = fetch ? REQ : IDLE;
                end else begin
                    baud_next = baud + 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Serial line and completion pulse, decoded from registered state so
    // reset forces the line high without waiting for a clock edge.
    // ------------------------------------------------------------------
    always_comb begin
        tx = 1'b1;
        case (state)
            START:   tx = 1'b0;
            DATA:    tx = shreg[0];
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY:  tx = parity_q;
`endif
            default: tx = 1'b1;
        endcase
    end

    assign word_done = (state == STOP) && baud_end;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - scoreboard bench for fifo_uart_tx

module tb_fifo_uart_tx;

    localparam int W = 16;
    localparam int C = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int NBITS = W + 3;
`else
    localparam int NBITS = W + 2;
`endif
    localparam int FRAME_LEN = NBITS * C;

    logic         clk;
    logic         rst;
    logic         en;
    logic         fifo_empty;
    logic [W-1:0] fifo_data;
    logic         fifo_re;
    logic         tx;
    logic         busy;
    logic         word_done;

    fifo_uart_tx #(.WIDTH(W), .CLKS_PER_BIT(C)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_re    (fifo_re),
        .tx         (tx),
        .busy       (busy),
        .word_done  (word_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] fifo_q [$];
    logic [W-1:0] exp_q  [$];

    // monitor statistics
    int cycle       = 0;
    int re_count    = 0;
    int re_gap      = 0;
    int last_re     = 0;
    int wd_count    = 0;
    int frame_count = 0;
    int busy_cycles = 0;
    int last_gap    = 0;
    int last_end    = 0;
    bit in_frame    = 0;
    int cnt         = 0;
    logic tx_buf [FRAME_LEN];
    logic wd_buf [FRAME_LEN];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // FIFO model: read data appears after the cycle in which re is high.
    initial begin
        fifo_empty = 1'b1;
        fifo_data  = '0;
    end
    always @(negedge clk) begin
        if (fifo_re) begin
            if (fifo_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL empty_read: fifo_re=1 with empty FIFO at cycle %0d", cycle);
            end else begin
                fifo_data = fifo_q.pop_front();
            end
        end
        fifo_empty = (fifo_q.size() == 0);
    end

    task automatic check_frame();
        bit           shape_ok;
        bit           wd_ok;
        logic [W-1:0] word;
        logic [W-1:0] e;
        logic         par;
        shape_ok = 1;
        wd_ok    = 1;
        word     = '0;
        par      = 1'b0;
        for (int b = 0; b < NBITS; b++)
            for (int k = 1; k < C; k++)
                if (tx_buf[b*C+k] !== tx_buf[b*C]) shape_ok = 0;
        if (tx_buf[0] !== 1'b0) shape_ok = 0;
        if (tx_buf[FRAME_LEN-1] !== 1'b1) shape_ok = 0;
        for (int i = 0; i < W; i++) word[i] = tx_buf[(i+1)*C];
`ifdef FIFO_UART_TX_PARITY_EN
        par = tx_buf[(W+1)*C];
`endif
        for (int i = 0; i < FRAME_LEN; i++)
            if (wd_buf[i] !== (i == FRAME_LEN-1)) wd_ok = 0;
        frame_count++;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame: got %0h with no expected word", word);
        end else begin
            e = exp_q.pop_front();
            chk("frame_data", word, e);
`ifdef FIFO_UART_TX_PARITY_EN
            chk("frame_parity", par, ^e);
`endif
        end
        chk("frame_shape", shape_ok, 1);
        chk("word_done_pos", wd_ok, 1);
    endtask

    // Monitor: receives frames from tx and compares against the scoreboard.
    always @(negedge clk) begin
        cycle++;
        if (!rst) begin
            in_frame = 0;
            cnt      = 0;
        end else begin
            if (busy) busy_cycles++;
            if (fifo_re) begin
                re_count++;
                re_gap  = cycle - last_re;
                last_re = cycle;
            end
            if (word_done) wd_count++;
            if (!in_frame && tx == 1'b0) begin
                in_frame = 1;
                cnt      = 0;
                last_gap = cycle - last_end - 1;
            end
            if (in_frame) begin
                tx_buf[cnt] = tx;
                wd_buf[cnt] = word_done;
                cnt++;
                if (cnt == FRAME_LEN) begin
                    in_frame = 0;
                    last_end = cycle;
                    check_frame();
                end
            end
        end
    end

    task automatic push(input logic [W-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
    endtask

    task automatic wait_idle(input string name);
        bit done;
        done = 0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            if (!busy) done = 1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_timeout: busy still high", name);
        end
    endtask

    task automatic wait_re(input string name);
        bit seen;
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (fifo_re) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_re_timeout: no fifo_re", name);
        end
    endtask

    task automatic quiet_window(input string name, input int n);
        int re0;
        int tx_low;
        int busy_hi;
        re0     = re_count;
        tx_low  = 0;
        busy_hi = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) tx_low++;
            if (busy !== 1'b0) busy_hi++;
        end
        chk({name, "_re"}, re_count - re0, 0);
        chk({name, "_tx_low"}, tx_low, 0);
        chk({name, "_busy"}, busy_hi, 0);
    endtask

    int re0, wd0, fr0, bc0;

    initial begin
        rst = 1'b0;
        en  = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_tx", tx, 1);
        chk("reset_fifo_re", fifo_re, 0);
        chk("reset_busy", busy, 0);
        chk("reset_word_done", word_done, 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // single word 16'h00A5
        re0 = re_count; wd0 = wd_count; fr0 = frame_count; bc0 = busy_cycles;
        push(16'h00A5);
        en = 1'b1;
        wait_idle("single");
        repeat (5) @(negedge clk);
        chk("single_re_pulses", re_count - re0, 1);
        chk("single_word_done", wd_count - wd0, 1);
        chk("single_frames", frame_count - fr0, 1);
        chk("single_busy_cycles", busy_cycles - bc0, FRAME_LEN + 2);

        // back-to-back 16'h0001 then 16'h8000
        re0 = re_count; wd0 = wd_count; fr0 = frame_count;
        push(16'h0001);
        push(16'h8000);
        wait_idle("b2b");
        repeat (5) @(negedge clk);
        chk("b2b_re_pulses", re_count - re0, 2);
        chk("b2b_re_spacing", re_gap, FRAME_LEN + 2);
        chk("b2b_gap", last_gap, 2);
        chk("b2b_word_done", wd_count - wd0, 2);
        chk("b2b_frames", frame_count - fr0, 2);

        // empty FIFO with en=1
        quiet_window("empty_gate", 100);

        // non-empty FIFO with en=0
        en = 1'b0;
        push(16'h1111);
        quiet_window("en_gate", 100);
        fifo_q.delete();
        exp_q.delete();
        repeat (3) @(negedge clk);

        // en dropped mid-frame with the FIFO still holding a word
        re0 = re_count; fr0 = frame_count;
        push(16'hFFFF);
        push(16'h5555);
        en = 1'b1;
        wait_re("endrop");
        repeat (20) @(negedge clk);
        en = 1'b0;
        wait_idle("endrop");
        repeat (20) @(negedge clk);
        chk("endrop_re_pulses", re_count - re0, 1);
        chk("endrop_frames", frame_count - fr0, 1);
        chk("endrop_fifo_left", fifo_q.size(), 1);
        chk("endrop_idle_busy", busy, 0);
        fifo_q.delete();
        exp_q.delete();
        repeat (3) @(negedge clk);

        // parity vectors 16'h0007 and 16'h0003
        re0 = re_count; fr0 = frame_count;
        push(16'h0007);
        push(16'h0003);
        en = 1'b1;
        wait_idle("parity");
        repeat (5) @(negedge clk);
        chk("parity_frames", frame_count - fr0, 2);
        chk("parity_re_spacing", re_gap, FRAME_LEN + 2);

        // asynchronous reset in the middle of DATA
        push(16'hA5A5);
        wait_re("reset_mid");
        repeat (15) @(negedge clk);
        chk("busy_before_reset", busy, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_reset_tx", tx, 1);
        chk("async_reset_fifo_re", fifo_re, 0);
        chk("async_reset_busy", busy, 0);
        void'(exp_q.pop_front());
        repeat (3) @(negedge clk);
        rst = 1'b1;
        quiet_window("post_reset", 50);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
